vector_sweep_ctrl: RTL

VECTOR_SWEEP_CTRL -- requirements
Module: vector_sweep_ctrl

---
 rtl/sweep_pkg.sv | 17 +
 rtl/sweep_settle_timer.sv | 32 +++
 rtl/vector_sweep_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared types and limits for the exhaustive vector sweep controller.
package sweep_pkg;

  localparam int N_IN_MAX   = 6;
  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } sweep_state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer: loaded while a vector is applied, then counts down while
// enabled. Expire fires on the last enabled cycle, so an enabled window
// lasts exactly load_val cycles.
module sweep_settle_timer
  import sweep_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         CK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count_reg;

  // Load takes precedence; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expire = en && (count_reg == W'(1));

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input-vector sweep controller: applies every vector 0..2**N_IN-1,
// waits SETTLE cycles, samples the single-bit response, compares it with the
// golden map and hands each result to a logger over a valid/ready handshake.
module vector_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   CK,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   golden,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   dut_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N_IN-1:0]        rsp_vec,
  output logic                   rsp_bit,
  output logic [(1<<N_IN)-1:0]   resp_map,
  output logic [N_IN:0]          mism_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  sweep_state_t    state_reg;
  sweep_state_t    state_next;
  logic [N_IN-1:0] vec_reg;
  logic [NV-1:0]   map_reg;
  logic [N_IN:0]   mism_reg;
  logic            settle_expire;

  sweep_settle_timer #(
    .W (SETTLE_W)
  ) u_settle (
    .CK       (CK),
    .reset    (reset),
    .load     (state_reg == ST_APPLY),
    .load_val (SETTLE_W'(SETTLE)),
    .en       (state_reg == ST_WAIT),
    .expire   (settle_expire)
  );

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (start) state_next = ST_APPLY;
        ST_APPLY:  state_next = ST_WAIT;
        ST_WAIT:   if (settle_expire) state_next = ST_SAMPLE;
        ST_SAMPLE: state_next = ST_EMIT;
        ST_EMIT:   if (rsp_ready) state_next = (vec_reg == VEC_LAST) ? ST_DONE : ST_APPLY;
        ST_DONE:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sweep datapath: clear on start, capture on sample, advance on transfer.
  // Abort freezes everything so partial results stay visible.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      vec_reg  <= '0;
      map_reg  <= '0;
      mism_reg <= '0;
    end else if (!abort) begin
      if ((state_reg == ST_IDLE) && start) begin
        vec_reg  <= '0;
        map_reg  <= '0;
        mism_reg <= '0;
      end
      if (state_reg == ST_SAMPLE) begin
        map_reg[vec_reg] <= dut_out;
        if (dut_out != golden[vec_reg]) begin
          mism_reg <= mism_reg + (N_IN+1)'(1);
        end
      end
      // The last vector never advances, so vec_out cannot wrap within a sweep.
      if ((state_reg == ST_EMIT) && rsp_ready && (vec_reg != VEC_LAST)) begin
        vec_reg <= vec_reg + N_IN'(1);
      end
    end
  end

  assign vec_out   = vec_reg;
  assign rsp_valid = (state_reg == ST_EMIT);
  assign rsp_vec   = vec_reg;
  assign rsp_bit   = map_reg[vec_reg];
  assign resp_map  = map_reg;
  assign mism_cnt  = mism_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);

endmodule
